// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, WIDTH-iteration shift-add multiply.
// Result and flags are held in registers until the consumer takes them.
module alu_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             illegal
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_NOT  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_EQ   = 4'd7;
   localparam logic [3:0] OP_SLTU = 4'd8;
   localparam logic [3:0] OP_SLL  = 4'd9;
   localparam logic [3:0] OP_SRL  = 4'd10;
   localparam logic [3:0] OP_SRA  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0]   add_full, sub_full;
   logic             add_ovf, sub_ovf;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cout, alu_ovf, alu_ill;

   // Shared adder/subtractor; sub carry-out is the no-borrow flag
   always_comb begin
      add_full = {1'b0, in_a} + {1'b0, in_b};
      sub_full = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
      add_ovf  = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_full[WIDTH-1] != in_a[WIDTH-1]);
      sub_ovf  = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_full[WIDTH-1] != in_a[WIDTH-1]);
      shamt    = in_b[SHW-1:0];
   end

   // Single-cycle result and flags for every non-multiply opcode
   always_comb begin
      alu_res  = '0;
      alu_cout = 1'b0;
      alu_ovf  = 1'b0;
      alu_ill  = 1'b0;
      case (op)
         OP_ADD:  begin alu_res = add_full[WIDTH-1:0]; alu_cout = add_full[WIDTH]; alu_ovf = add_ovf; end
         OP_SUB:  begin alu_res = sub_full[WIDTH-1:0]; alu_cout = sub_full[WIDTH]; alu_ovf = sub_ovf; end
         OP_NOT:  alu_res = ~in_a;
         OP_AND:  alu_res = in_a & in_b;
         OP_OR:   alu_res = in_a | in_b;
         OP_XOR:  alu_res = in_a ^ in_b;
         OP_SLT:  begin
            alu_res = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
            alu_ovf = sub_ovf;
         end
         OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, in_a == in_b};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
         OP_SLL:  alu_res = in_a << shamt;
         OP_SRL:  alu_res = in_a >> shamt;
         OP_SRA:  alu_res = $signed(in_a) >>> shamt;
         OP_MUL:  alu_res = '0;
         default: alu_ill = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = (op == OP_MUL) ? BUSY : DONE;
         BUSY:    if (cnt_q == CW'(WIDTH)) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // Operand capture, shift-add iterations and result/flag registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         res      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               if (op == OP_MUL) begin
                  mcand_q  <= in_a;
                  mplier_q <= in_b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
               end else begin
                  res      <= alu_res;
                  cout     <= alu_cout;
                  overflow <= alu_ovf;
                  zero     <= (alu_res == '0);
                  illegal  <= alu_ill;
               end
            end
            BUSY: if (cnt_q == CW'(WIDTH)) begin
               res      <= acc_q;
               cout     <= 1'b0;
               overflow <= 1'b0;
               zero     <= (acc_q == '0);
               illegal  <= 1'b0;
            end else begin
               if (mplier_q[0]) acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, multi-cycle corner sequences,
// and randomized ops against an arithmetic reference model.
module tb_alu_seq;
   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       op = '0;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] res;
   logic             cout, overflow, zero, illegal;

   int n_vec = 0;
   int n_err = 0;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .cout(cout), .overflow(overflow), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        z;
      logic        il;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference model from plain integer arithmetic
   function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic c, output logic v,
                                 output logic il);
      longint unsigned ua = {32'd0, a};
      longint unsigned ub = {32'd0, b};
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned u;
      longint          s;
      int              sh = int'(b[4:0]);
      r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
      case (o)
         4'd0: begin u = ua + ub; r = u[31:0]; c = u[32]; s = sa + sb;
                     v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'd1: begin u = ua - ub; r = u[31:0]; c = (ua >= ub); s = sa - sb;
                     v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'd2: r = ~a;
         4'd3: r = a & b;
         4'd4: r = a | b;
         4'd5: r = a ^ b;
         4'd6: begin r = (sa < sb) ? 32'd1 : 32'd0; s = sa - sb;
                     v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'd7: r = (a == b) ? 32'd1 : 32'd0;
         4'd8: r = (ua < ub) ? 32'd1 : 32'd0;
         4'd9: r = a << sh;
         4'd10: r = a >> sh;
         4'd11: begin s = sa >>> sh; r = s[31:0]; end
         4'd12: begin u = ua * ub; r = u[31:0]; end
         default: il = 1'b1;
      endcase
   endfunction

   // Present one op, return edges from accept until out_valid is seen
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      @(negedge clk);
      check("in_ready_before_issue", 64'(in_ready), 64'd1);
      in_valid = 1'b1; op = o; in_a = a; in_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0; op = 4'($urandom); in_a = $urandom; in_b = $urandom;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_drop", 64'(out_valid), 64'd0);
      check("in_ready_rise", 64'(in_ready), 64'd1);
   endtask

   function automatic logic [63:0] pack_exp(input logic [31:0] r, input logic c, input logic v,
                                            input logic il);
      return 64'({1'b1, in_ready_exp_done(), r, c, v, (r == 32'd0), il});
   endfunction

   function automatic logic in_ready_exp_done();
      return 1'b0;
   endfunction

   vec_t vt[$];

   initial begin
      int lat;
      logic [31:0] r;
      logic c, v, il;
      logic [31:0] picks[5];

      vt.push_back('{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0});
      vt.push_back('{4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0});
      vt.push_back('{4'd1,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{4'd6,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0});
      vt.push_back('{4'd8,  32'h80000000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0});
      vt.push_back('{4'd11, 32'h80000010, 32'h00000024, 32'hF8000001, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{4'd7,  32'h00001234, 32'h00001234, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{4'd2,  32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{4'd4,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{4'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0});
      vt.push_back('{4'd9,  32'h00000001, 32'hFFFFFFE1, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{4'd10, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0});
      vt.push_back('{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
      vt.push_back('{4'd13, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1});
      vt.push_back('{4'd15, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1});
      vt.push_back('{4'd12, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{4'd12, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0});
      vt.push_back('{4'd12, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0});

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 64'({out_valid, res, cout, overflow, zero, illegal}), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD with out_ready already high: one cycle of out_valid, then back to IDLE
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; op = 4'd0; in_a = 32'h7FFFFFFF; in_b = 32'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("add_first_result", 64'({out_valid, res, cout, overflow, zero, illegal}),
            64'({1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0}));
      @(posedge clk); #1;
      check("add_first_release", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
      out_ready = 1'b0;

      // Directed table
      foreach (vt[i]) begin
         issue(vt[i].op, vt[i].a, vt[i].b, lat);
         check($sformatf("vec%0d_op%0d_latency", i, vt[i].op), 64'(lat),
               (vt[i].op == 4'd12) ? 64'(WIDTH + 1) : 64'd0);
         check($sformatf("vec%0d_op%0d_result", i, vt[i].op),
               64'({out_valid, in_ready, res, cout, overflow, zero, illegal}),
               64'({1'b1, 1'b0, vt[i].res, vt[i].c, vt[i].v, vt[i].z, vt[i].il}));
         consume();
      end

      // Back-pressure: hold EQ result for 10 cycles while new requests are offered
      issue(4'd7, 32'h1234, 32'h1234, lat);
      check("eq_hold_latency", 64'(lat), 64'd0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         in_valid = 1'b1; op = 4'd0; in_a = 32'd1; in_b = 32'd1;
         @(posedge clk); #1;
         check($sformatf("eq_hold_cycle%0d", k),
               64'({out_valid, in_ready, res, cout, overflow, zero, illegal}),
               64'({1'b1, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0}));
      end
      in_valid = 1'b0;
      consume();

      // Reset in the middle of a multiply discards it
      @(negedge clk);
      in_valid = 1'b1; op = 4'd12; in_a = 32'hFFFFFFFD; in_b = 32'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midmul_reset_outputs", 64'({out_valid, in_ready, res, cout, overflow, zero, illegal}),
            64'({1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
      repeat (40) @(posedge clk);
      #1;
      check("midmul_reset_no_emit", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
      issue(4'd14, 32'hDEADBEEF, 32'h1, lat);
      check("illegal14_latency", 64'(lat), 64'd0);
      check("illegal14_result", 64'({out_valid, res, cout, overflow, zero, illegal}),
            64'({1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1}));
      consume();

      // Randomized ops against the reference model
      picks = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1};
      for (int n = 0; n < 250; n++) begin
         logic [3:0]  ro;
         logic [31:0] ra, rb;
         ro = 4'($urandom_range(0, 15));
         ra = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : 32'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : 32'($urandom);
         model(ro, ra, rb, r, c, v, il);
         issue(ro, ra, rb, lat);
         check($sformatf("rnd%0d_op%0d_latency", n, ro), 64'(lat),
               (ro == 4'd12) ? 64'(WIDTH + 1) : 64'd0);
         check($sformatf("rnd%0d_op%0d_a%h_b%h", n, ro, ra, rb),
               64'({out_valid, res, cout, overflow, zero, illegal}),
               64'({1'b1, r, c, v, (r == 32'd0), il}));
         consume();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the lab combinational ALU.
- Generic WIDTH. Adds a proper subtract (a − b), unsigned compare, shifts and a multi-cycle shift-add multiply. Registers all results and flags.
- Sits between the operand-fetch stage and writeback.
- Accepts one operation at a time over a valid/ready handshake and holds the result until the consumer takes it.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- SHW, $clog2(WIDTH), shift-amount field width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation
- op  input  4  opcode
- in_a  input  WIDTH  operand A, two's complement
- in_b  input  WIDTH  operand B, two's complement
- out_valid  output  1  result registers valid
- out_ready  input  1  consumer takes result
- res  output  WIDTH  result
- cout  output  1  carry out / no-borrow flag
- overflow  output  1  signed overflow
- zero  output  1  res == 0
- illegal  output  1  opcode 13..15 was issued

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; out_valid=0; res=0; cout=0; overflow=0; zero=0; illegal=0.
  - The multiply accumulator, multiplicand, multiplier and counter are cleared.
  - Reset mid-multiply or while holding a result discards it; nothing is emitted.
- Opcodes:
  - 0 ADD: a+b. cout = carry out of bit WIDTH-1. overflow = a,b same sign and res sign differs.
  - 1 SUB: a−b = a+~b+1. cout = 1 when no borrow (a ≥ b unsigned). overflow = a,b signs differ and res sign ≠ a sign.
  - 2 NOT: ~a.
  - 3 AND, 4 OR, 5 XOR: bitwise.
  - 6 SLT: res = 1 if a<b signed, else 0. Computed as (sub sign XOR sub overflow).
  - 7 EQ: res = (a==b).
  - 8 SLTU: res = 1 if a<b unsigned, else 0.
  - 9 SLL, 10 SRL, 11 SRA: a shifted by b[SHW-1:0]. Upper bits of b are ignored.
  - 12 MUL: low WIDTH bits of a*b. Identical for signed and unsigned operands.
  - 13–15: res=0 and illegal=1.
  - cout=0 and overflow=0 for every opcode other than 0, 1 and 6 (6 reports the subtraction's overflow in overflow, with cout=0).
  - zero = (res==0) for all opcodes.
- State machine: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE). An operation is accepted at an edge where in_valid && in_ready.
  - IDLE, accept of a non-MUL op: result and flags are computed from the presented inputs and registered at the same edge; go to DONE. Latency is 1: out_valid is high in the following cycle.
  - IDLE, accept of MUL: latch a into the multiplicand, b into the multiplier, clear the accumulator, counter=0; go to BUSY.
  - BUSY, each edge:
    - If multiplier[0], add the multiplicand to the accumulator (mod 2^WIDTH).
    - Multiplicand <<= 1; multiplier >>= 1; counter++.
    - After WIDTH iterations: res = accumulator, flags follow the flag rules above; go to DONE.
    - MUL out_valid rises WIDTH+1 edges after the accept edge.
  - DONE: out_valid=1. res and flags stay stable until an edge with out_ready=1, then go to IDLE and drop out_valid.
  - A new operation cannot be accepted in that same edge; throughput is at most one op per 2 cycles.
- Back-pressure: out_ready=0 holds DONE indefinitely with outputs unchanged.
- in_valid outside IDLE is ignored. Inputs are not sampled during BUSY or DONE.
- The operation is accepted whatever out_ready is doing.

Test Plan:
- WIDTH=32. Reset, then ADD a=0x7FFFFFFF b=1 with out_ready=1 → next cycle out_valid=1, res=0x80000000, overflow=1, cout=0, zero=0. The following cycle out_valid=0 and in_ready=1.
- SUB a=5 b=5 → res=0, zero=1, cout=1, overflow=0. SUB a=3 b=5 → res=0xFFFFFFFE, cout=0.
- SLT a=0x80000000 b=1 → res=1. SLTU with the same operands → res=0. SRA a=0x80000010 b=0x24 (shift 4) → res=0xF8000001.
- MUL a=0xFFFFFFFD (−3) b=7 → in_ready low for 33 cycles. out_valid rises at the 33rd edge after accept, res=0xFFFFFFEB.
- Hold out_ready=0 for 10 cycles after an EQ a=b=0x1234 → res=1 held stable and in_ready=0. Pulse out_ready → out_valid drops and in_ready rises the next cycle.
- Start MUL, assert rst_n=0 for one edge mid-BUSY → outputs 0 and state IDLE. op=14 afterwards → res=0, illegal=1, zero=1.
